// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, funct encodings, sequencer state and helpers
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MULT = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000001;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic is_multicycle(input logic [3:0] code);
    return (code == ALU_MULT) || (code == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational aluOp/funct decode; shift ops gated by ALU_CTRL_SHIFT_EN
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       illegal,
  output logic       multicycle
);

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (aluOp)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      2'b11: illegal = 1'b1;
      default: begin
        case (funct)
          F_ADD:  code = ALU_ADD;
          F_SUB:  code = ALU_SUB;
          F_MULT: code = ALU_MULT;
          F_DIV:  code = ALU_DIV;
          F_AND:  code = ALU_AND;
          F_OR:   code = ALU_OR;
          F_NOR:  code = ALU_NOR;
          F_XOR:  code = ALU_XOR;
`ifdef ALU_CTRL_SHIFT_EN
          F_SLL:  code = ALU_SLL;
          F_SRL:  code = ALU_SRL;
`endif
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign multicycle = is_multicycle(code);

endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU control word with mult/div sequencing and ID/EX stall
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W      = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        aluOp,
  input  logic [5:0]        funct,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_ctrl_out,
  output logic              ctrl_valid,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic              illegal
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT);

  if (CTRL_W < 4) begin : g_bad_ctrl_w
    $error("alu_control_seq: CTRL_W must be at least 4");
  end
  if (MULT_CYCLES < 2 || DIV_CYCLES < 2) begin : g_bad_lat
    $error("alu_control_seq: latencies must be at least 2");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sc_valid;
  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             dec_multi;
  logic             accept;

  alu_ctrl_decode u_decode (
    .aluOp      (aluOp),
    .funct      (funct),
    .code       (dec_code),
    .illegal    (dec_illegal),
    .multicycle (dec_multi)
  );

  // All status outputs come from registers only, so stall has no input-to-output path.
  assign busy       = (state == BUSY);
  assign done       = busy && (cnt == '0);
  assign stall      = busy && !done;
  assign ctrl_valid = sc_valid || done;
  assign accept     = valid_in && !flush && ((state == IDLE) || done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      alu_ctrl_out <= '0;
      sc_valid     <= 1'b0;
      illegal      <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      cnt      <= '0;
      sc_valid <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept) begin
      alu_ctrl_out <= CTRL_W'(dec_code);
      illegal      <= dec_illegal;
      if (dec_multi) begin
        state    <= BUSY;
        cnt      <= (dec_code == ALU_MULT) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
        sc_valid <= 1'b0;
      end else begin
        state    <= IDLE;
        cnt      <= '0;
        sc_valid <= 1'b1;
      end
    end else begin
      sc_valid <= 1'b0;
      illegal  <= 1'b0;
      if (busy) begin
        if (cnt == '0) state <= IDLE;
        else           cnt   <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed self-checking bench for alu_control_seq
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid_in = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic       flush = 1'b0;
  logic [3:0] alu_ctrl_out;
  logic       ctrl_valid, busy, done, stall, illegal;

  int total = 0;
  int bad = 0;

  alu_control_seq #(.CTRL_W(4), .MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .aluOp        (alu_op),
    .funct        (funct),
    .flush        (flush),
    .alu_ctrl_out (alu_ctrl_out),
    .ctrl_valid   (ctrl_valid),
    .busy         (busy),
    .done         (done),
    .stall        (stall),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] fn);
    alu_op   = op;
    funct    = fn;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"op00_add", 2'b00, 6'b111111, 4'b0000, 1'b0};
    vecs[1]  = '{"op01_sub", 2'b01, 6'b111111, 4'b0001, 1'b0};
    vecs[2]  = '{"op11_ill", 2'b11, 6'b100100, 4'b0000, 1'b1};
    vecs[3]  = '{"f_add",    2'b10, 6'b100000, 4'b0000, 1'b0};
    vecs[4]  = '{"f_sub",    2'b10, 6'b100010, 4'b0001, 1'b0};
    vecs[5]  = '{"f_and",    2'b10, 6'b100100, 4'b0100, 1'b0};
    vecs[6]  = '{"f_or",     2'b10, 6'b100101, 4'b0101, 1'b0};
    vecs[7]  = '{"f_nor",    2'b10, 6'b100111, 4'b0110, 1'b0};
    vecs[8]  = '{"f_xor",    2'b10, 6'b100110, 4'b0111, 1'b0};
    vecs[9]  = '{"f_bad",    2'b10, 6'b111111, 4'b0000, 1'b1};
`ifdef ALU_CTRL_SHIFT_EN
    vecs[10] = '{"f_sll",    2'b10, 6'b000000, 4'b1000, 1'b0};
    vecs[11] = '{"f_srl",    2'b10, 6'b000001, 4'b1001, 1'b0};
`else
    vecs[10] = '{"f_sll",    2'b10, 6'b000000, 4'b0000, 1'b1};
    vecs[11] = '{"f_srl",    2'b10, 6'b000001, 4'b0000, 1'b1};
`endif

    #2 rst_n = 1'b0;
    #1;
    chk("rst_code", alu_ctrl_out, 0);
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_illegal", illegal, 0);
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back single-cycle decodes, one per clock.
    valid_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      alu_op = vecs[i].op;
      funct  = vecs[i].fn;
      step();
      chk({vecs[i].nm, "_code"}, alu_ctrl_out, vecs[i].code);
      chk({vecs[i].nm, "_ill"}, illegal, vecs[i].ill);
      chk({vecs[i].nm, "_valid"}, ctrl_valid, 1);
      chk({vecs[i].nm, "_stall"}, stall, 0);
    end
    valid_in = 1'b0;
    step();
    chk("idle_valid", ctrl_valid, 0);
    chk("idle_ill", illegal, 0);
    chk("idle_hold_code", alu_ctrl_out, vecs[11].code);

    // Mult: busy T+1..T+4, stall T+1..T+3, done/ctrl_valid only at T+4.
    issue(2'b10, 6'b011000);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("mult_busy_%0d", i), busy, 1);
      chk($sformatf("mult_stall_%0d", i), stall, (i < 4) ? 1 : 0);
      chk($sformatf("mult_done_%0d", i), done, (i == 4) ? 1 : 0);
      chk($sformatf("mult_valid_%0d", i), ctrl_valid, (i == 4) ? 1 : 0);
      chk($sformatf("mult_code_%0d", i), alu_ctrl_out, 2);
      step();
    end
    chk("mult_after_busy", busy, 0);
    chk("mult_after_done", done, 0);

    // Div with a mult held upstream the whole time; mult enters at T+32.
    issue(2'b10, 6'b011010);
    funct    = 6'b011000;
    valid_in = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      if (i == 33) valid_in = 1'b0;
      chk($sformatf("chain_busy_%0d", i), busy, 1);
      chk($sformatf("chain_done_%0d", i), done, (i == 32 || i == 36) ? 1 : 0);
      chk($sformatf("chain_stall_%0d", i), stall, (i == 32 || i == 36) ? 0 : 1);
      if (i == 32) chk("chain_div_code", alu_ctrl_out, 3);
      if (i == 33) chk("chain_mult_code", alu_ctrl_out, 2);
      step();
    end
    chk("chain_end_busy", busy, 0);

    // Flush at T+5 of a div drops the op and the simultaneous valid_in.
    issue(2'b10, 6'b011010);
    repeat (4) step();
    chk("flush_pre_busy", busy, 1);
    flush    = 1'b1;
    alu_op   = 2'b10;
    funct    = 6'b100101;
    valid_in = 1'b1;
    step();
    flush    = 1'b0;
    valid_in = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", ctrl_valid, 0);
    chk("flush_ill", illegal, 0);
    chk("flush_code_kept", alu_ctrl_out, 3);
    for (int i = 0; i < 30; i++) begin
      if (done || busy) chk($sformatf("flush_quiet_%0d", i), {busy, done}, 0);
      step();
    end
    chk("flush_quiet_done", done, 0);

    // Asynchronous reset in cycle 10 of a div.
    issue(2'b10, 6'b011010);
    repeat (9) step();
    chk("rst_mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_code", alu_ctrl_out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_valid", ctrl_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    issue(2'b10, 6'b100101);
    chk("post_rst_code", alu_ctrl_out, 5);
    chk("post_rst_valid", ctrl_valid, 1);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
